// File: rtl/univ_rotate_reg_pkg.sv
// rtl/univ_rotate_reg_pkg.sv - shared operation codes for the universal rotate register
package univ_rotate_reg_pkg;

   localparam logic [1:0] CTRL_LOAD = 2'b00;
   localparam logic [1:0] CTRL_ROR  = 2'b01;
   localparam logic [1:0] CTRL_ROL  = 2'b10;
   localparam logic [1:0] CTRL_HOLD = 2'b11;

endpackage

// File: rtl/univ_rotate_reg.sv
// rtl/univ_rotate_reg.sv - DW-bit register with load, rotate left/right and hold
module univ_rotate_reg
   import univ_rotate_reg_pkg::*;
#(
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          async_rst,
   input  logic [1:0]    ctrl,
   input  logic [DW-1:0] data,
   output logic [DW-1:0] q
);

   logic [DW-1:0] r;

   // Despite its name, async_rst is sampled only at the rising edge and wins over ctrl.
   always_ff @(posedge clk) begin
      if (async_rst) begin
         r <= '0;
      end else begin
         case (ctrl)
            CTRL_LOAD: r <= data;
            CTRL_ROR:  r <= {r[0], r[DW-1:1]};
            CTRL_ROL:  r <= {r[DW-2:0], r[DW-1]};
            CTRL_HOLD: r <= r;
            default:   r <= r;
         endcase
      end
   end

   assign q = r;

endmodule

// File: tb/tb_univ_rotate_reg.sv
// tb/tb_univ_rotate_reg.sv - directed and randomized self-checking bench for univ_rotate_reg
module tb_univ_rotate_reg;

   localparam int DW   = 4;
   localparam int MASK = (1 << DW) - 1;

   logic          clk = 1'b0;
   logic          async_rst = 1'b0;
   logic [1:0]    ctrl = 2'b11;
   logic [DW-1:0] data = '0;
   logic [DW-1:0] q;

   int tests  = 0;
   int failed = 0;
   int model  = 0;

   univ_rotate_reg #(.DW(DW)) dut (
      .clk       (clk),
      .async_rst (async_rst),
      .ctrl      (ctrl),
      .data      (data),
      .q         (q)
   );

   always #5 clk = ~clk;

   function automatic int rot_left(input int v);
      return ((v << 1) | (v >> (DW - 1))) & MASK;
   endfunction

   function automatic int rot_right(input int v);
      return ((v >> 1) | ((v & 1) << (DW - 1))) & MASK;
   endfunction

   function automatic int popcount(input int v);
      int n = 0;
      for (int i = 0; i < DW; i++) n += (v >> i) & 1;
      return n;
   endfunction

   task automatic check(input string tag, input logic [DW-1:0] expected);
      tests++;
      assert (q === expected) else begin
         failed++;
         $error("FAIL %s: observed=%b expected=%b", tag, q, expected);
      end
   endtask

   // Apply one operation across a rising edge, advance the model, compare #1 after the edge.
   task automatic step(input string tag, input logic rst, input logic [1:0] c,
                       input logic [DW-1:0] d);
      logic [DW-1:0] exp_q;
      async_rst = rst;
      ctrl      = c;
      data      = d;
      @(posedge clk);
      #1;
      if (rst)            model = 0;
      else if (c == 2'b00) model = int'(d);
      else if (c == 2'b01) model = rot_right(model);
      else if (c == 2'b10) model = rot_left(model);
      exp_q = model[DW-1:0];
      check(tag, exp_q);
   endtask

   initial begin
      int prev_model;
      logic [DW-1:0] pre;
      logic [DW-1:0] pc_q;

      // Reset overrides a load of all ones
      step("reset", 1'b1, 2'b00, 4'b1111);
      check("reset_const", 4'b0000);

      // Load then rotate left, then hold
      step("load_1011", 1'b0, 2'b00, 4'b1011);
      check("load_1011_const", 4'b1011);
      step("rol1", 1'b0, 2'b10, 4'b0000);
      check("rol1_const", 4'b0111);
      step("rol2", 1'b0, 2'b10, 4'b0000);
      check("rol2_const", 4'b1110);
      step("hold1", 1'b0, 2'b11, 4'b0101);
      step("hold2", 1'b0, 2'b11, 4'b0101);
      check("hold_const", 4'b1110);

      // Load then rotate right, then hold
      step("load_1011b", 1'b0, 2'b00, 4'b1011);
      step("ror1", 1'b0, 2'b01, 4'b0000);
      check("ror1_const", 4'b1101);
      step("ror2", 1'b0, 2'b01, 4'b0000);
      check("ror2_const", 4'b1110);
      step("hold3", 1'b0, 2'b11, 4'b0000);
      check("hold3_const", 4'b1110);

      // Wrap-around in both directions
      step("load_1000", 1'b0, 2'b00, 4'b1000);
      step("wrap_l1", 1'b0, 2'b10, 4'b0000);
      check("wrap_l1_const", 4'b0001);
      step("wrap_l2", 1'b0, 2'b10, 4'b0000);
      step("wrap_l3", 1'b0, 2'b10, 4'b0000);
      check("wrap_l3_const", 4'b0100);
      step("wrap_l4", 1'b0, 2'b10, 4'b0000);
      check("wrap_l4_const", 4'b1000);
      step("load_0001", 1'b0, 2'b00, 4'b0001);
      step("wrap_r1", 1'b0, 2'b01, 4'b0000);
      check("wrap_r1_const", 4'b1000);
      step("wrap_r2", 1'b0, 2'b01, 4'b0000);
      step("wrap_r3", 1'b0, 2'b01, 4'b0000);
      step("wrap_r4", 1'b0, 2'b01, 4'b0000);
      check("wrap_r4_const", 4'b0001);

      // Reset in the middle of a rotate sequence, then resume with a load
      step("load_0110", 1'b0, 2'b00, 4'b0110);
      step("mid_rol", 1'b0, 2'b10, 4'b0000);
      check("mid_rol_const", 4'b1100);
      step("mid_reset", 1'b1, 2'b10, 4'b0000);
      check("mid_reset_const", 4'b0000);
      step("resume_load", 1'b0, 2'b00, 4'b0101);
      check("resume_load_const", 4'b0101);

      // Input changes between edges must not reach q
      pre  = q;
      ctrl = 2'b00;
      data = 4'b1010;
      #2;
      async_rst = 1'b1;
      #1;
      async_rst = 1'b0;
      check("between_edges", pre);
      step("after_glitch_hold", 1'b0, 2'b11, 4'b1111);
      check("after_glitch_hold_const", 4'b0101);

      // Randomized cross-check against the arithmetic model
      for (int i = 0; i < 600; i++) begin
         logic          r_rst;
         logic [1:0]    r_ctrl;
         logic [DW-1:0] r_data;
         r_rst      = ($urandom_range(0, 24) == 0);
         r_ctrl     = 2'($urandom_range(0, 3));
         r_data     = DW'($urandom);
         prev_model = model;
         step("random", r_rst, r_ctrl, r_data);
         if (!r_rst && r_ctrl != 2'b00) begin
            pc_q = q;
            tests++;
            assert (popcount(int'(pc_q)) == popcount(prev_model)) else begin
               failed++;
               $error("FAIL popcount: observed=%0d expected=%0d",
                      popcount(int'(pc_q)), popcount(prev_model));
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
